// File: rtl/dcache_stage.sv
// dcache_stage: direct-mapped write-back write-allocate data cache stage.
// Ports: clk/reset, enable_cache, tlb_result/dataReg/ldSt_enable request,
//   destReg_addr/we/bp pass-through, cache_result, stall, line-wide memory
//   port (mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready).
//   Optional DCACHE_STATS_EN adds hit_count/miss_count.
module dcache_stage #(
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_cache,
  input  logic [15:0]                  tlb_result,
  input  logic [15:0]                  dataReg,
  input  logic [1:0]                   ldSt_enable,
  input  logic [2:0]                   destReg_addr_input,
  input  logic                         we_input,
  input  logic [1:0]                   bp_input,
  output logic [15:0]                  cache_result,
  output logic [2:0]                   destReg_addr_output,
  output logic                         we_output,
  output logic [1:0]                   bp_output,
  output logic                         stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [15:0]                  mem_addr,
  output logic [16*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [16*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                         mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                  hit_count,
  output logic [15:0]                  miss_count
`endif
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = 16 - 1 - OB - IB;
  localparam int LW = 16 * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE,
    EVICT,
    FILL
  } state_t;

  state_t state, nextState;

  logic [LW-1:0]        dataArr [NUM_LINES];
  logic [TB-1:0]        tagArr  [NUM_LINES];
  logic [NUM_LINES-1:0] validArr;
  logic [NUM_LINES-1:0] dirtyArr;

  logic [OB-1:0] reqOff;
  logic [IB-1:0] reqIdx;
  logic [TB-1:0] reqTag;
  logic          isLoad, isStore, memOp;
  logic          hit, missDet, regUpdate, fillDone;
  logic [15:0]   hitWord;

  assign reqOff  = tlb_result[OB:1];
  assign reqIdx  = tlb_result[OB+IB:OB+1];
  assign reqTag  = tlb_result[15:OB+IB+1];
  assign isLoad  = (ldSt_enable == 2'b01);
  assign isStore = (ldSt_enable == 2'b10);
  assign memOp   = isLoad | isStore;

  assign hit     = validArr[reqIdx] && (tagArr[reqIdx] == reqTag);
  assign missDet = (state == IDLE) && memOp && !hit;
  assign stall   = (state != IDLE) || missDet;
  assign hitWord = dataArr[reqIdx][{reqOff, 4'b0000} +: 16];

  // Not stalling implies IDLE with either no memory op or a hit.
  assign regUpdate = enable_cache && !stall;
  assign fillDone  = (state == FILL) && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Memory outputs depend only on state and the held request,
  // so they stay stable for the whole transaction.
  always_comb begin
    nextState = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (missDet) begin
          if (validArr[reqIdx] && dirtyArr[reqIdx]) nextState = EVICT;
          else                                      nextState = FILL;
        end
      end
      EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tagArr[reqIdx], reqIdx, {(OB+1){1'b0}}};
        mem_wdata = dataArr[reqIdx];
        if (mem_ready) nextState = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {reqTag, reqIdx, {(OB+1){1'b0}}};
        if (mem_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      validArr <= '0;
      dirtyArr <= '0;
    end else if (fillDone) begin
      dataArr[reqIdx]  <= mem_rdata;
      tagArr[reqIdx]   <= reqTag;
      validArr[reqIdx] <= 1'b1;
      dirtyArr[reqIdx] <= 1'b0;
    end else if (regUpdate && isStore) begin
      dataArr[reqIdx][{reqOff, 4'b0000} +: 16] <= dataReg;
      dirtyArr[reqIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_result        <= '0;
      destReg_addr_output <= '0;
      we_output           <= 1'b0;
      bp_output           <= '0;
    end else if (enable_cache) begin
      if (stall) begin
        destReg_addr_output <= '0;
        we_output           <= 1'b0;
        bp_output           <= '0;
      end else begin
        cache_result        <= isLoad ? hitWord : tlb_result;
        destReg_addr_output <= destReg_addr_input;
        we_output           <= we_input;
        bp_output           <= bp_input;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // refill marks the re-lookup after a fill so it is not counted as a hit.
  logic refill;

  always_ff @(posedge clk) begin
    if (reset) begin
      refill     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (fillDone)       refill <= 1'b1;
      else if (regUpdate) refill <= 1'b0;
      if (missDet && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
      if (regUpdate && memOp && !refill && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_stage.sv
// tb_dcache_stage: directed bench for dcache_stage with a memory responder
// and an architectural model of memory contents and line residency.
module tb_dcache_stage;

  localparam int NL  = 4;
  localparam int WPL = 8;
  localparam int LW  = 16 * WPL;

  logic          clk;
  logic          reset;
  logic          enable_cache;
  logic [15:0]   tlb_result;
  logic [15:0]   dataReg;
  logic [1:0]    ldSt_enable;
  logic [2:0]    destReg_addr_input;
  logic          we_input;
  logic [1:0]    bp_input;
  logic [15:0]   cache_result;
  logic [2:0]    destReg_addr_output;
  logic          we_output;
  logic [1:0]    bp_output;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef DCACHE_STATS_EN
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
`endif

  dcache_stage #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable_cache        (enable_cache),
    .tlb_result          (tlb_result),
    .dataReg             (dataReg),
    .ldSt_enable         (ldSt_enable),
    .destReg_addr_input  (destReg_addr_input),
    .we_input            (we_input),
    .bp_input            (bp_input),
    .cache_result        (cache_result),
    .destReg_addr_output (destReg_addr_output),
    .we_output           (we_output),
    .bp_output           (bp_output),
    .stall               (stall),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ready           (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count           (hit_count),
    .miss_count          (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Main-memory contents: explicit writes, else a fixed address pattern.
  logic [15:0] memArr [int];

  function automatic logic [15:0] memInit(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1111;
  endfunction

  function automatic logic [15:0] memRd(input logic [15:0] a);
    if (memArr.exists(int'(a))) return memArr[int'(a)];
    return memInit(a);
  endfunction

  // Memory responder: raises mem_ready in the curLat-th request cycle.
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] w0;
  } txn_t;

  txn_t txLog[$];
  int   curLat    = 1;
  bit   holdReady = 1'b0;

  initial begin
    int reqCycles;
    reqCycles = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (!mem_req) begin
        reqCycles = 0;
      end else begin
        if (reqCycles == 0)
          txLog.push_back('{mem_we, mem_addr, mem_wdata[15:0]});
        reqCycles++;
        if (reqCycles >= curLat && !holdReady) begin
          for (int w = 0; w < WPL; w++) begin
            if (mem_we)
              memArr[int'(mem_addr) + 2*w] = mem_wdata[16*w +: 16];
            else
              mem_rdata[16*w +: 16] = memRd(mem_addr + 16'(2*w));
          end
          mem_ready = 1'b1;
          reqCycles = 0;
        end
      end
    end
  end

  // Architectural model: committed memory plus stores still held in
  // dirty lines; residency is tracked only as index -> tag.
  bit          lval   [NL];
  bit          ldirty [NL];
  logic [9:0]  ltag   [NL];
  logic [15:0] committed [int];
  logic [15:0] pending   [int];
  int          mHit = 0;
  int          mMiss = 0;

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    if (pending.exists(int'(a)))   return pending[int'(a)];
    if (committed.exists(int'(a))) return committed[int'(a)];
    return memInit(a);
  endfunction

  task automatic flushLine(input int idx);
    logic [15:0] wa;
    for (int w = 0; w < WPL; w++) begin
      wa = {ltag[idx], idx[1:0], w[2:0], 1'b0};
      if (pending.exists(int'(wa))) begin
        committed[int'(wa)] = pending[int'(wa)];
        pending.delete(int'(wa));
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) begin
      lval[i]   = 1'b0;
      ldirty[i] = 1'b0;
    end
    pending.delete();
    mHit  = 0;
    mMiss = 0;
  endtask

  logic [15:0] expRes;
  logic        expWe;
  logic [2:0]  expDest;
  logic [1:0]  expBp;
  int          armSeq = 0;

  // Compare process: registered result after each op, bubbles after
  // every stall cycle, and memory-port stability within a transaction.
  initial begin
    int          doneSeq;
    logic        pStall, pReset, pEn, pReq, pRdy, pWe;
    logic [15:0] pRes, pAddr;
    doneSeq = 0;
    pStall = 1'b0; pReset = 1'b1; pEn = 1'b1;
    pReq = 1'b0; pRdy = 1'b0; pWe = 1'b0;
    pRes = '0; pAddr = '0;
    forever begin
      @(negedge clk);
      if (armSeq != doneSeq) begin
        chk("result", cache_result, expRes);
        chk("weOut", we_output, expWe);
        chk("destOut", destReg_addr_output, expDest);
        chk("bpOut", bp_output, expBp);
        doneSeq = armSeq;
      end
      if (pStall && !pReset && pEn) begin
        chk("bubbleWe", we_output, 1'b0);
        chk("bubbleBp", bp_output, 2'b00);
        chk("bubbleDest", destReg_addr_output, 3'b000);
        chk("bubbleHold", cache_result, pRes);
      end
      if (mem_req && pReq && !pRdy) begin
        chk("memAddrStable", mem_addr, pAddr);
        chk("memWeStable", mem_we, pWe);
      end
      if (mem_we) chk("memWeNeedsReq", mem_req, 1'b1);
      pStall = stall;
      pReset = reset;
      pEn    = enable_cache;
      pRes   = cache_result;
      pReq   = mem_req;
      pRdy   = mem_ready;
      pWe    = mem_we;
      pAddr  = mem_addr;
    end
  end

  task automatic doOp(input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] d, input logic [2:0] dst,
                      input logic w, input logic [1:0] b,
                      input int lat, input string nm,
                      output int stallCnt);
    int         idx, cnt, expS;
    logic [9:0] tg;
    bit         memop, hit;
    @(posedge clk);
    #2;
    curLat             = lat;
    ldSt_enable        = op;
    tlb_result         = a;
    dataReg            = d;
    destReg_addr_input = dst;
    we_input           = w;
    bp_input           = b;
    idx   = int'(a[5:4]);
    tg    = a[15:6];
    memop = (op == 2'b01) || (op == 2'b10);
    hit   = lval[idx] && (ltag[idx] == tg);
    expS  = 0;
    if (memop && !hit) begin
      if (lval[idx] && ldirty[idx]) begin
        expS = 2*lat + 1;
        flushLine(idx);
      end else begin
        expS = lat + 1;
      end
      lval[idx]   = 1'b1;
      ltag[idx]   = tg;
      ldirty[idx] = 1'b0;
      mMiss++;
    end else if (memop) begin
      mHit++;
    end
    if (op == 2'b01) begin
      expRes = modelRead({a[15:1], 1'b0});
    end else begin
      expRes = a;
      if (op == 2'b10) begin
        pending[int'({a[15:1], 1'b0})] = d;
        ldirty[idx] = 1'b1;
      end
    end
    #1;
    cnt = 0;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk);
      #3;
    end
    chk({nm, " stallCycles"}, cnt, expS);
    stallCnt = cnt;
    @(posedge clk);
    #1;
    expWe   = w;
    expDest = dst;
    expBp   = b;
    armSeq++;
    ldSt_enable = 2'b00;
    we_input    = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sc, n0;
    logic [15:0] sRes;
    logic        sWe;
    reset              = 1'b1;
    enable_cache       = 1'b1;
    tlb_result         = '0;
    dataReg            = '0;
    ldSt_enable        = 2'b00;
    destReg_addr_input = '0;
    we_input           = 1'b0;
    bp_input           = '0;
    memArr[16'h0040]    = 16'hBEEF;
    committed[16'h0040] = 16'hBEEF;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    chk("rstResult", cache_result, 16'h0000);
    chk("rstWe", we_output, 1'b0);
    chk("rstDest", destReg_addr_output, 3'd0);
    chk("rstBp", bp_output, 2'd0);
    chk("rstStall", stall, 1'b0);
    chk("rstMemReq", mem_req, 1'b0);
    chk("rstMemAddr", mem_addr, 16'h0000);
`ifdef DCACHE_STATS_EN
    chk("rstHitCnt", hit_count, 16'd0);
    chk("rstMissCnt", miss_count, 16'd0);
`endif
    reset = 1'b0;

    n0 = txLog.size();
    doOp(2'b01, 16'h0040, 16'h0, 3'd2, 1'b1, 2'd1, 3, "ld40", sc);
    chk("ld40StallLit", sc, 4);
    chk("ld40DataLit", cache_result, 16'hBEEF);
    chk("ld40WeLit", we_output, 1'b1);
    chk("ld40Txns", txLog.size(), n0 + 1);
    if (txLog.size() == n0 + 1) begin
      chk("ld40TxWe", txLog[n0].we, 1'b0);
      chk("ld40TxAddr", txLog[n0].addr, 16'h0040);
    end

    n0 = txLog.size();
    doOp(2'b01, 16'h0042, 16'h0, 3'd1, 1'b1, 2'd0, 3, "ld42", sc);
    chk("ld42DataLit", cache_result, 16'h5311);
    chk("ld42NoReq", txLog.size(), n0);

    doOp(2'b10, 16'h0040, 16'h1234, 3'd0, 1'b0, 2'd0, 2, "st40", sc);
    chk("st40Result", cache_result, 16'h0040);

    n0 = txLog.size();
    doOp(2'b01, 16'h0140, 16'h0, 3'd4, 1'b1, 2'd3, 2, "ld140", sc);
    chk("ld140StallLit", sc, 5);
    chk("ld140Txns", txLog.size(), n0 + 2);
    if (txLog.size() == n0 + 2) begin
      chk("evictWe", txLog[n0].we, 1'b1);
      chk("evictAddr", txLog[n0].addr, 16'h0040);
      chk("evictWord0", txLog[n0].w0, 16'h1234);
      chk("fillWe", txLog[n0+1].we, 1'b0);
      chk("fillAddr", txLog[n0+1].addr, 16'h0140);
    end

    doOp(2'b01, 16'h0040, 16'h0, 3'd3, 1'b1, 2'd0, 2, "ld40b", sc);
    chk("ld40bDataLit", cache_result, 16'h1234);

    doOp(2'b00, 16'h5A5A, 16'h0, 3'd5, 1'b1, 2'd2, 1, "nonmem", sc);
    chk("nonmemResLit", cache_result, 16'h5A5A);
    chk("nonmemWeLit", we_output, 1'b1);
    chk("nonmemDestLit", destReg_addr_output, 3'd5);
    chk("nonmemStallLit", sc, 0);

    doOp(2'b11, 16'h1357, 16'h0, 3'd3, 1'b1, 2'd2, 1, "op11", sc);

    // Hit store with enable_cache low: outputs hold, no array write.
    @(posedge clk);
    #2;
    sRes               = cache_result;
    sWe                = we_output;
    enable_cache       = 1'b0;
    ldSt_enable        = 2'b10;
    tlb_result         = 16'h0042;
    dataReg            = 16'hDEAD;
    we_input           = 1'b1;
    destReg_addr_input = 3'd7;
    #1;
    chk("disStall", stall, 1'b0);
    @(posedge clk);
    #1;
    chk("disHoldRes", cache_result, sRes);
    chk("disHoldWe", we_output, sWe);
    enable_cache = 1'b1;
    ldSt_enable  = 2'b00;
    we_input     = 1'b0;

    doOp(2'b01, 16'h0042, 16'h0, 3'd1, 1'b1, 2'd0, 1, "ld42b", sc);
    chk("ld42bDataLit", cache_result, 16'h5311);

    doOp(2'b01, 16'h0010, 16'h0, 3'd2, 1'b1, 2'd1, 1, "ld10", sc);
    chk("ld10StallLit", sc, 2);

    doOp(2'b10, 16'h0020, 16'h7777, 3'd0, 1'b0, 2'd0, 2, "st20", sc);
    doOp(2'b01, 16'h0020, 16'h0, 3'd6, 1'b1, 2'd0, 2, "ld20", sc);
    chk("ld20DataLit", cache_result, 16'h7777);

    // Reset in the middle of a fill with mem_ready withheld.
    holdReady = 1'b1;
    @(posedge clk);
    #2;
    ldSt_enable = 2'b01;
    tlb_result  = 16'h0030;
    repeat (3) @(posedge clk);
    #1;
    chk("midFillReq", mem_req, 1'b1);
    chk("midFillAddr", mem_addr, 16'h0030);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abortReqDrop", mem_req, 1'b0);
    reset       = 1'b0;
    ldSt_enable = 2'b00;
    holdReady   = 1'b0;
    modelReset();

    doOp(2'b01, 16'h0030, 16'h0, 3'd1, 1'b1, 2'd0, 2, "reload30", sc);
    chk("reload30StallLit", sc, 3);
    doOp(2'b01, 16'h0032, 16'h0, 3'd1, 1'b1, 2'd0, 2, "ld32", sc);
    doOp(2'b01, 16'h0034, 16'h0, 3'd1, 1'b1, 2'd0, 2, "ld34", sc);
    doOp(2'b01, 16'h0036, 16'h0, 3'd1, 1'b1, 2'd0, 2, "ld36", sc);
`ifdef DCACHE_STATS_EN
    @(posedge clk);
    #1;
    chk("missCountLit", miss_count, 16'd1);
    chk("hitCountLit", hit_count, 16'd3);
`endif

    doOp(2'b01, 16'h0020, 16'h0, 3'd2, 1'b1, 2'd0, 2, "ld20lost", sc);
    chk("ld20lostDataLit", cache_result, 16'h3111);

    doOp(2'b10, 16'h0024, 16'hA5A5, 3'd0, 1'b0, 2'd0, 1, "st24", sc);
    doOp(2'b01, 16'h0064, 16'h0, 3'd3, 1'b1, 2'd1, 1, "ld64", sc);
    chk("ld64StallLit", sc, 3);
    doOp(2'b01, 16'h0024, 16'h0, 3'd3, 1'b1, 2'd1, 1, "ld24", sc);
    chk("ld24DataLit", cache_result, 16'hA5A5);

`ifdef DCACHE_STATS_EN
    @(posedge clk);
    #1;
    chk("missCountModel", miss_count, mMiss);
    chk("hitCountModel", hit_count, mHit);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
